// File: rtl/reg_file_n.sv
// Register bank of 2**NB_ADDR words with one write port and two registered read ports.
// The read word is picked bit-slice by bit-slice through gate-level muxn trees; same-cycle writes are forwarded.

module muxn #(
    parameter int NB_SEL = 3
) (
    input  logic [(1<<NB_SEL)-1:0] ins,
    input  logic [NB_SEL-1:0]      sel,
    output logic                   out
);
    localparam int N = 1 << NB_SEL;

    // Heap-ordered binary tree: node k has children 2k+1 and 2k+2, leaves at N-1..2N-2.
    wire [2*N-2:0] node;

    for (genvar i = 0; i < N; i++) begin : g_leaf
        buf u_buf (node[N-1+i], ins[i]);
    end

    for (genvar d = 0; d < NB_SEL; d++) begin : g_level
        for (genvar j = 0; j < (1 << d); j++) begin : g_node
            localparam int K = (1 << d) - 1 + j;
            wire nsel, pick_lo, pick_hi;
            not u_not (nsel, sel[NB_SEL-1-d]);
            and u_and_lo (pick_lo, node[2*K+1], nsel);
            and u_and_hi (pick_hi, node[2*K+2], sel[NB_SEL-1-d]);
            or  u_or (node[K], pick_lo, pick_hi);
        end
    end

    assign out = node[0];
endmodule

module reg_file_n #(
    parameter int NB_ADDR  = 3,
    parameter int WIDTH    = 8,
    parameter int ZERO_REG = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [NB_ADDR-1:0] waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               re,
    input  logic [NB_ADDR-1:0] raddr_a,
    input  logic [NB_ADDR-1:0] raddr_b,
    output logic [WIDTH-1:0]   rdata_a,
    output logic [WIDTH-1:0]   rdata_b,
    output logic               rvalid
);
    localparam int N = 1 << NB_ADDR;
    localparam bit HAS_ZERO = (ZERO_REG != 0);

    logic [WIDTH-1:0] mem [N];
    logic [WIDTH-1:0] word_a, word_b;
    logic [WIDTH-1:0] next_a, next_b;
    logic             wr_ok, zero_a, zero_b, fwd_a, fwd_b;

    for (genvar b = 0; b < WIDTH; b++) begin : g_slice
        logic [N-1:0] col;
        for (genvar w = 0; w < N; w++) begin : g_col
            assign col[w] = mem[w][b];
        end
        muxn #(.NB_SEL(NB_ADDR)) u_mux_a (.ins(col), .sel(raddr_a), .out(word_a[b]));
        muxn #(.NB_SEL(NB_ADDR)) u_mux_b (.ins(col), .sel(raddr_b), .out(word_b[b]));
    end

    assign wr_ok  = we && !(HAS_ZERO && (waddr == '0));
    assign zero_a = HAS_ZERO && (raddr_a == '0);
    assign zero_b = HAS_ZERO && (raddr_b == '0);
    // Write-first: a read of the word being written sees the new data.
    assign fwd_a  = we && (raddr_a == waddr) && !zero_a;
    assign fwd_b  = we && (raddr_b == waddr) && !zero_b;
    assign next_a = zero_a ? '0 : (fwd_a ? wdata : word_a);
    assign next_b = zero_b ? '0 : (fwd_b ? wdata : word_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a <= '0;
            rdata_b <= '0;
            rvalid  <= 1'b0;
        end else begin
            rvalid <= re;
            if (re) begin
                rdata_a <= next_a;
                rdata_b <= next_b;
            end
        end
    end
endmodule

// File: tb/tb_reg_file_n.sv
// Directed and random checks of reg_file_n against an array model, for ZERO_REG=1 and ZERO_REG=0 instances.

module tb_reg_file_n;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       we, re;
    logic [2:0] waddr, raddr_a, raddr_b;
    logic [7:0] wdata;
    logic [7:0] rd_a1, rd_b1, rd_a0, rd_b0;
    logic       rv1, rv0;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    reg_file_n #(.NB_ADDR(3), .WIDTH(8), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rd_a1), .rdata_b(rd_b1), .rvalid(rv1));

    reg_file_n #(.NB_ADDR(3), .WIDTH(8), .ZERO_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rd_a0), .rdata_b(rd_b0), .rvalid(rv0));

    always #5 clk = ~clk;

    // Behavioural model: plain arrays, z=1 for the zero-register instance, z=0 for the other.
    int m_mem [2][8];
    int e_a [2];
    int e_b [2];
    bit e_v;

    function automatic int model_read(int z, int addr);
        if (z == 1 && addr == 0) return 0;
        if (we && int'(waddr) == addr) return int'(wdata);
        return m_mem[z][addr];
    endfunction

    initial begin
        for (int z = 0; z < 2; z++) begin
            e_a[z] = 0; e_b[z] = 0;
            for (int i = 0; i < 8; i++) m_mem[z][i] = 0;
        end
        e_v = 0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int z = 0; z < 2; z++) begin
                e_a[z] = 0; e_b[z] = 0;
                for (int i = 0; i < 8; i++) m_mem[z][i] = 0;
            end
            e_v = 0;
        end else begin
            for (int z = 0; z < 2; z++) begin
                if (re) begin
                    e_a[z] = model_read(z, int'(raddr_a));
                    e_b[z] = model_read(z, int'(raddr_b));
                end
                if (we && !(z == 1 && waddr == 3'd0)) m_mem[z][waddr] = int'(wdata);
            end
            e_v = re;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("model rdata_a z1", int'(rd_a1), e_a[1]);
            chk("model rdata_b z1", int'(rd_b1), e_b[1]);
            chk("model rvalid z1", int'(rv1), int'(e_v));
            chk("model rdata_a z0", int'(rd_a0), e_a[0]);
            chk("model rdata_b z0", int'(rd_b0), e_b[0]);
            chk("model rvalid z0", int'(rv0), int'(e_v));
        end
    end

    task automatic cyc(input logic w, input logic [2:0] wa, input logic [7:0] wd,
                       input logic r, input logic [2:0] ra, input logic [2:0] rb);
        we = w; waddr = wa; wdata = wd; re = r; raddr_a = ra; raddr_b = rb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        we = 0; waddr = 0; wdata = 0; re = 0; raddr_a = 0; raddr_b = 0;
        rst_n = 1'b0;
        #1;
        started = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: read after reset with no writes
        cyc(0, 0, 8'h00, 1, 3'd5, 3'd7);
        chk("t1 rdata_a", int'(rd_a1), 'h00);
        chk("t1 rdata_b", int'(rd_b1), 'h00);
        chk("t1 rvalid", int'(rv1), 1);

        // 2: write then read, then hold with re=0
        cyc(1, 3'd3, 8'hA5, 0, 0, 0);
        cyc(1, 3'd6, 8'h3C, 0, 0, 0);
        cyc(0, 0, 8'h00, 1, 3'd3, 3'd6);
        chk("t2 rdata_a", int'(rd_a1), 'hA5);
        chk("t2 rdata_b", int'(rd_b1), 'h3C);
        cyc(0, 0, 8'h00, 0, 3'd1, 3'd2);
        chk("t2 hold a", int'(rd_a1), 'hA5);
        chk("t2 hold b", int'(rd_b1), 'h3C);
        chk("t2 rvalid low", int'(rv1), 0);

        // 3: forwarding on both ports, then stored value
        cyc(1, 3'd4, 8'h5A, 1, 3'd4, 3'd4);
        chk("t3 fwd a", int'(rd_a1), 'h5A);
        chk("t3 fwd b", int'(rd_b1), 'h5A);
        cyc(0, 0, 8'h00, 1, 3'd4, 3'd0);
        chk("t3 stored", int'(rd_a1), 'h5A);

        // 4: word 0 behaviour for both ZERO_REG settings, including forwarding to 0
        cyc(1, 3'd0, 8'hFF, 1, 3'd0, 3'd3);
        chk("t4 fwd zero z1", int'(rd_a1), 'h00);
        chk("t4 fwd zero z0", int'(rd_a0), 'hFF);
        cyc(0, 0, 8'h00, 1, 3'd0, 3'd0);
        chk("t4 read zero z1", int'(rd_a1), 'h00);
        chk("t4 read zero z0", int'(rd_a0), 'hFF);

        // 5: fill every word, then asynchronous reset between edges
        for (int i = 0; i < 8; i++) cyc(1, 3'(i), 8'(8'h10 + i), 0, 0, 0);
        cyc(0, 0, 8'h00, 1, 3'd7, 3'd1);
        chk("t5 pre a", int'(rd_a1), 'h17);
        chk("t5 pre b", int'(rd_b1), 'h11);
        we = 1; waddr = 3'd2; wdata = 8'hEE; re = 1; raddr_a = 3'd2; raddr_b = 3'd5;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5 async a", int'(rd_a1), 0);
        chk("t5 async b", int'(rd_b1), 0);
        chk("t5 async rvalid", int'(rv1), 0);
        chk("t5 async a z0", int'(rd_a0), 0);
        @(posedge clk);
        #1;
        chk("t5 held in reset", int'(rv1), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 8'h00, 1, 3'(i), 3'(7 - i));
            chk("t5 cleared a", int'(rd_a0), 0);
            chk("t5 cleared b", int'(rd_b0), 0);
        end

        // 6: random traffic, checked by the model every cycle
        for (int n = 0; n < 10000; n++) begin
            cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
